// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encodings, button indices and ALU opcodes
package alu_seq_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        RESULT  = 2'b11
    } state_e;

    localparam int BTN_ENTER = 0;
    localparam int BTN_BACK  = 1;
    localparam int BTN_CLEAR = 2;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_SRA = 6'h03;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU, signed two's-complement operands with wrap-around
module alu
    import alu_seq_pkg::*;
#(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6
) (
    input  logic [SIZEDATA-1:0] data_a_i,
    input  logic [SIZEDATA-1:0] data_b_i,
    input  logic [SIZEOP-1:0]   op_i,
    output logic [SIZEDATA-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            SIZEOP'(OP_ADD): result_o = data_a_i + data_b_i;
            SIZEOP'(OP_SUB): result_o = data_a_i - data_b_i;
            SIZEOP'(OP_AND): result_o = data_a_i & data_b_i;
            SIZEOP'(OP_OR):  result_o = data_a_i | data_b_i;
            SIZEOP'(OP_XOR): result_o = data_a_i ^ data_b_i;
            SIZEOP'(OP_NOR): result_o = ~(data_a_i | data_b_i);
            SIZEOP'(OP_SRL): result_o = data_a_i >> data_b_i;
            SIZEOP'(OP_SRA): result_o = $signed(data_a_i) >>> data_b_i;
            default:         result_o = '0;
        endcase
    end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-FF synchroniser, stability counter and rising-edge pulse
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          deb_prev_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synced level agrees with the debounced level restarts the count.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            pulse_q    <= deb_q & ~deb_prev_q;
            cnt_q      <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_seq_top.sv
// rtl/alu_seq_top.sv - button-sequenced operand/opcode entry around the ALU
// with a registered result, VALID flag and LED display.
module alu_seq_top
    import alu_seq_pkg::*;
#(
    parameter int SIZEDATA        = 8,
    parameter int SIZEOP          = 6,
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [SIZEDATA-1:0]  SWITCHES,
    input  logic [N_BUTTONS-1:0] BUTTONS,
    output logic [SIZEDATA-1:0]  LEDS,
    output logic [1:0]           STATE,
    output logic                 VALID
);

    logic [N_BUTTONS-1:0] pulse;
    state_e               state_q;
    logic [SIZEDATA-1:0]  datoa_q, datob_q, result_q, leds_q;
    logic [SIZEOP-1:0]    opcode_q;
    logic                 valid_q;
    logic [SIZEDATA-1:0]  alu_result;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (CLK),
            .rst_ni (RST_N),
            .btn_i  (BUTTONS[i]),
            .pulse_o(pulse[i])
        );
    end

    alu #(
        .SIZEDATA(SIZEDATA),
        .SIZEOP  (SIZEOP)
    ) u_alu (
        .data_a_i(datoa_q),
        .data_b_i(datob_q),
        .op_i    (opcode_q),
        .result_o(alu_result)
    );

    // Button actions come last so CLEAR/exit assignments override the RESULT-state loads.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= LOAD_A;
            datoa_q  <= '0;
            datob_q  <= '0;
            opcode_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            leds_q   <= '0;
        end else begin
            if (state_q == RESULT) begin
                result_q <= alu_result;
                valid_q  <= 1'b1;
                if (valid_q) begin
                    leds_q <= result_q;
                end
            end else begin
                leds_q <= SWITCHES;
            end

            if (pulse[BTN_CLEAR]) begin
                state_q  <= LOAD_A;
                datoa_q  <= '0;
                datob_q  <= '0;
                opcode_q <= '0;
                result_q <= '0;
                valid_q  <= 1'b0;
            end else if (pulse[BTN_BACK]) begin
                case (state_q)
                    LOAD_A:  state_q <= LOAD_A;
                    LOAD_B:  state_q <= LOAD_A;
                    LOAD_OP: state_q <= LOAD_B;
                    RESULT: begin
                        state_q <= LOAD_OP;
                        valid_q <= 1'b0;
                    end
                    default: state_q <= LOAD_A;
                endcase
            end else if (pulse[BTN_ENTER]) begin
                case (state_q)
                    LOAD_A: begin
                        datoa_q <= SWITCHES;
                        state_q <= LOAD_B;
                    end
                    LOAD_B: begin
                        datob_q <= SWITCHES;
                        state_q <= LOAD_OP;
                    end
                    LOAD_OP: begin
                        opcode_q <= SWITCHES[SIZEOP-1:0];
                        state_q  <= RESULT;
                    end
                    RESULT: begin
                        state_q <= LOAD_A;
                        valid_q <= 1'b0;
                    end
                    default: state_q <= LOAD_A;
                endcase
            end
        end
    end

    assign LEDS  = leds_q;
    assign STATE = state_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_alu_seq_top.sv
// tb/tb_alu_seq_top.sv - scoreboard bench for alu_seq_top with a short debounce window
module tb_alu_seq_top;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] SWITCHES;
    logic [2:0] BUTTONS;
    logic [7:0] LEDS;
    logic [1:0] STATE;
    logic       VALID;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb_q[$];

    alu_seq_top #(
        .SIZEDATA       (8),
        .SIZEOP         (6),
        .N_BUTTONS      (3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .SWITCHES(SWITCHES),
        .BUTTONS (BUTTONS),
        .LEDS    (LEDS),
        .STATE   (STATE),
        .VALID   (VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] model_alu(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [2:0] mask);
        BUTTONS = mask;
        repeat (8) tick();
        BUTTONS = 3'b000;
        repeat (8) tick();
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        RST_N    = 1'b0;
        SWITCHES = 8'h00;
        BUTTONS  = 3'b000;
        repeat (3) tick();
        n_cmp++; if (STATE !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", STATE); end
        n_cmp++; if (LEDS !== 8'h00) begin n_err++; $display("FAIL reset_leds: got %h want 00", LEDS); end
        n_cmp++; if (VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", VALID); end
        RST_N = 1'b1;
        tick();
        SWITCHES = 8'h5A;
        tick();
        n_cmp++; if (LEDS !== 8'h5A) begin n_err++; $display("FAIL echo_leds: got %h want 5a", LEDS); end
    endtask

    task automatic test_bounce_and_hold();
        SWITCHES = 8'd100;
        for (int i = 0; i < 10; i++) begin
            BUTTONS = (i % 2 == 0) ? 3'b001 : 3'b000;
            repeat (2) tick();
        end
        BUTTONS = 3'b000;
        repeat (10) tick();
        n_cmp++; if (STATE !== 2'b00) begin n_err++; $display("FAIL bounce_state: got %b want 00", STATE); end
        BUTTONS = 3'b001;
        repeat (7) tick();
        n_cmp++; if (STATE !== 2'b00) begin n_err++; $display("FAIL hold_early: got %b want 00", STATE); end
        tick();
        n_cmp++; if (STATE !== 2'b01) begin n_err++; $display("FAIL hold_edge: got %b want 01", STATE); end
        repeat (2) tick();
        BUTTONS = 3'b000;
        repeat (10) tick();
        n_cmp++; if (STATE !== 2'b01) begin n_err++; $display("FAIL hold_single: got %b want 01", STATE); end
    endtask

    task automatic test_add();
        bit         ok;
        logic [7:0] exp;
        SWITCHES = 8'd27;
        press(3'b001);
        n_cmp++; if (STATE !== 2'b10) begin n_err++; $display("FAIL add_load_op: got %b want 10", STATE); end
        SWITCHES = 8'h20;
        sb_q.push_back(model_alu(8'd100, 8'd27, 6'h20));
        BUTTONS = 3'b001;
        repeat (8) tick();
        n_cmp++; if (STATE !== 2'b11) begin n_err++; $display("FAIL add_state: got %b want 11", STATE); end
        n_cmp++; if (VALID !== 1'b0) begin n_err++; $display("FAIL add_valid_early: got %b want 0", VALID); end
        tick();
        n_cmp++; if (VALID !== 1'b1) begin n_err++; $display("FAIL add_valid_edge: got %b want 1", VALID); end
        BUTTONS = 3'b000;
        repeat (8) tick();
        wait_valid(ok);
        tick();
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || LEDS !== exp) begin n_err++; $display("FAIL add_result: got %h want %h valid_seen %0d", LEDS, exp, ok); end
    endtask

    task automatic test_back();
        bit         ok;
        logic [7:0] exp;
        BUTTONS = 3'b010;
        repeat (8) tick();
        n_cmp++; if (STATE !== 2'b10) begin n_err++; $display("FAIL back_state: got %b want 10", STATE); end
        n_cmp++; if (VALID !== 1'b0) begin n_err++; $display("FAIL back_valid: got %b want 0", VALID); end
        BUTTONS = 3'b000;
        repeat (8) tick();
        SWITCHES = 8'h22;
        sb_q.push_back(model_alu(8'd100, 8'd27, 6'h22));
        press(3'b001);
        wait_valid(ok);
        tick();
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || LEDS !== exp) begin n_err++; $display("FAIL sub_result: got %h want %h valid_seen %0d", LEDS, exp, ok); end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                          input string name);
        bit         ok;
        logic [7:0] exp;
        press(3'b001);
        n_cmp++; if (STATE !== 2'b00 || VALID !== 1'b0) begin n_err++; $display("FAIL %s_exit: got state %b valid %b want 00 0", name, STATE, VALID); end
        SWITCHES = a;
        press(3'b001);
        SWITCHES = b;
        press(3'b001);
        SWITCHES = {2'b00, op};
        sb_q.push_back(model_alu(a, b, op));
        press(3'b001);
        wait_valid(ok);
        tick();
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || LEDS !== exp) begin n_err++; $display("FAIL %s_result: got %h want %h valid_seen %0d", name, LEDS, exp, ok); end
    endtask

    task automatic test_wrap_and();
        run_op(8'd100, 8'd28, 6'h20, "wrap");
        run_op(8'hF3, 8'h3C, 6'h24, "and");
    endtask

    task automatic test_clear_collision();
        press(3'b001);
        SWITCHES = 8'h11;
        press(3'b001);
        SWITCHES = 8'h22;
        press(3'b001);
        n_cmp++; if (STATE !== 2'b10) begin n_err++; $display("FAIL clr_pre_state: got %b want 10", STATE); end
        SWITCHES = 8'h24;
        press(3'b101);
        n_cmp++; if (STATE !== 2'b00) begin n_err++; $display("FAIL clr_state: got %b want 00", STATE); end
        n_cmp++; if (VALID !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", VALID); end
        n_cmp++; if (dut.datoa_q !== 8'h00 || dut.datob_q !== 8'h00) begin n_err++; $display("FAIL clr_operands: got %h %h want 00 00", dut.datoa_q, dut.datob_q); end
        n_cmp++; if (dut.opcode_q !== 6'h00 || dut.result_q !== 8'h00) begin n_err++; $display("FAIL clr_op_result: got %h %h want 00 00", dut.opcode_q, dut.result_q); end
    endtask

    task automatic test_reset_mid_debounce();
        SWITCHES = 8'h33;
        press(3'b001);
        n_cmp++; if (STATE !== 2'b01) begin n_err++; $display("FAIL rst_pre_state: got %b want 01", STATE); end
        BUTTONS = 3'b001;
        repeat (4) tick();
        RST_N = 1'b0;
        #1;
        n_cmp++; if (STATE !== 2'b00 || LEDS !== 8'h00) begin n_err++; $display("FAIL rst_async: got state %b leds %h want 00 00", STATE, LEDS); end
        n_cmp++; if (dut.datoa_q !== 8'h00) begin n_err++; $display("FAIL rst_discard: got %h want 00", dut.datoa_q); end
        BUTTONS = 3'b000;
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (20) tick();
        n_cmp++; if (STATE !== 2'b00) begin n_err++; $display("FAIL rst_stale_pulse: got %b want 00", STATE); end
    endtask

    initial begin
        test_reset();
        test_bounce_and_hold();
        test_add();
        test_back();
        test_wrap_and();
        test_clear_collision();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
